// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 size codes, FSM state
// encoding and default geometry.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int ADDR_W_DEF      = 16;
  localparam int DEPTH_DEF       = 4096;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_align.sv
// Combinational size/alignment unit: byte enables and lane-replicated store
// data, sign/zero-extended load value, misalign and illegal-funct3 flags.
module dmem_align
  import dmem_responder_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  f3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_val,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_word[gi*8 +: 8];
  end

  assign sel_byte = lane[addr_lo];
  assign sel_half = addr_lo[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    be       = 4'b0000;
    wdata_sh = 32'd0;
    load_val = 32'd0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (f3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        load_val = (f3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
      end
      F3_H, F3_HU: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        load_val = (f3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
      end
      F3_W: begin
        misalign = |addr_lo;
        be       = 4'b1111;
        wdata_sh = wdata;
        load_val = rdata_word;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants only make sense for loads.
    if (we && f3[2]) illegal = 1'b1;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, owning the
// data RAM and a programmable access latency before the response is presented.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam int          CNT_W      = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               req_ready_reg;
  logic               rsp_valid_reg;
  logic               rsp_err_reg;
  logic               rsp_load_reg;
  logic               we_reg;
  logic [2:0]         f3_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_word_reg;

  logic               acc_from_req;
  logic               acc_we;
  logic [2:0]         acc_f3;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic               acc_err;
  logic               access_fire;
  logic               out_of_range;
  logic [IDX_W-1:0]   acc_idx;

  logic [3:0]         be;
  logic [31:0]        wdata_sh;
  logic [31:0]        load_val;
  logic               misalign;
  logic               illegal;

  // With zero wait the access happens on the accepting edge, so it must see the
  // live request; otherwise (and throughout RESP) the latched copy is used.
  assign acc_from_req = (state_reg == ST_IDLE);
  assign acc_we       = acc_from_req ? req_we    : we_reg;
  assign acc_f3       = acc_from_req ? req_f3    : f3_reg;
  assign acc_addr     = acc_from_req ? req_addr  : addr_reg;
  assign acc_wdata    = acc_from_req ? req_wdata : wdata_reg;
  assign acc_idx      = acc_addr[IDX_W+1:2];

  assign out_of_range = ({1'b0, acc_addr} >= ADDR_LIMIT) || (|(acc_addr >> ADDR_W));
  assign acc_err      = misalign | illegal | out_of_range;

  // The counter is on its last step when it holds 1; it reaches 0 on the access edge.
  assign access_fire = (WAIT_CYCLES == 0) ? (state_reg == ST_IDLE && req_valid)
                                          : (state_reg == ST_WAIT && cnt_reg == CNT_W'(1));

  dmem_align u_align (
    .we        (acc_we),
    .f3        (acc_f3),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rdata_word(rd_word_reg),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .load_val  (load_val),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  always_ff @(posedge clk) begin
    if (access_fire && !acc_err) begin
      if (acc_we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[acc_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
        end
      end else begin
        rd_word_reg <= mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_load_reg  <= 1'b0;
      we_reg        <= 1'b0;
      f3_reg        <= 3'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg        <= req_we;
            f3_reg        <= req_f3;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            cnt_reg       <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= acc_err;
              rsp_load_reg  <= !acc_err && !acc_we;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg     <= ST_RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= acc_err;
            rsp_load_reg  <= !acc_err && !acc_we;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_load_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_load_reg ? load_val : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, checked
// against a byte-array memory model with directed and random transactions.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        req_valid2 = 1'b0, rsp_ready2 = 1'b0;
  logic        req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_rdata2;
  logic        req_valid0 = 1'b0, rsp_ready0 = 1'b0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int tests = 0;
  int fails = 0;
  logic [7:0] mm [2][64];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(16), .DEPTH(4096), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we), .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  dmem_responder #(.ADDR_W(16), .DEPTH(4096), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // w selects the instance: 0 = WAIT_CYCLES 2, 1 = WAIT_CYCLES 0
  function automatic logic g_rdy(input int w); return w ? req_ready0 : req_ready2; endfunction
  function automatic logic g_rv(input int w);  return w ? rsp_valid0 : rsp_valid2; endfunction
  function automatic logic g_err(input int w); return w ? rsp_err0 : rsp_err2; endfunction
  function automatic logic [31:0] g_rd(input int w); return w ? rsp_rdata0 : rsp_rdata2; endfunction

  task automatic set_valid(input int w, input logic v);
    if (w != 0) req_valid0 = v; else req_valid2 = v;
  endtask

  task automatic set_rready(input int w, input logic v);
    if (w != 0) rsp_ready0 = v; else rsp_ready2 = v;
  endtask

  // Reference: RV32I size/sign rules applied to a plain byte array.
  function automatic void model(input int w, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    int sz;
    logic [31:0] v;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]) ||
          (addr >= 32'h4000) || ((addr % sz) != 0);
    rd  = 32'd0;
    if (!err && addr + sz <= 64) begin
      if (we) begin
        for (int k = 0; k < sz; k++) mm[w][addr + k] = wdata[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < sz; k++) v = v | (32'(mm[w][addr + k]) << (8*k));
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endfunction

  task automatic txn(input int w, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd_o, output logic err_o);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    int          lat;
    model(w, we, f3, addr, wdata, exp_rd, exp_err);
    @(negedge clk);
    req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
    set_valid(w, 1'b1);
    n = 0;
    while (!g_rdy(w) && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(g_rdy(w)), 32'd1);
    @(posedge clk);
    #1;
    set_valid(w, 1'b0);
    req_we = 1'($urandom); req_f3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!g_rv(w) && lat < 20);
    chk("latency", 32'(lat), (w != 0) ? 32'd1 : 32'd3);
    chk("rdata", g_rd(w), exp_rd);
    chk("err", 32'(g_err(w)), 32'(exp_err));
    chk("busy_ready", 32'(g_rdy(w)), 32'd0);
    rd_o = g_rd(w);
    err_o = g_err(w);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(g_rv(w)), 32'd1);
      chk("hold_rdata", g_rd(w), exp_rd);
      chk("hold_ready", 32'(g_rdy(w)), 32'd0);
    end
    set_rready(w, 1'b1);
    @(posedge clk);
    #1;
    set_rready(w, 1'b0);
    $display("[TB] dut%0d we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             w, we, f3, addr, wdata, rd_o, err_o, lat);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h4000 + ($urandom & 32'hFFF);
    if (r == 1) return 32'h8000_0000 | 32'($urandom_range(0, 63));
    return 32'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    for (int w = 0; w < 2; w++) for (int a = 0; a < 64; a++) mm[w][a] = 8'd0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready2", 32'(req_ready2), 32'd1);
    chk("rst_valid2", 32'(rsp_valid2), 32'd0);
    chk("rst_rdata2", rsp_rdata2, 32'd0);
    chk("rst_err2", 32'(rsp_err2), 32'd0);
    chk("rst_ready0", 32'(req_ready0), 32'd1);
    chk("rst_valid0", 32'(rsp_valid0), 32'd0);

    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 64; a += 4) txn(w, 1'b1, F3_W, 32'(a), 32'd0, 0, rd, er);

    // Reset in the middle of a store's wait: the store must not land.
    @(negedge clk);
    req_we = 1'b1; req_f3 = F3_W; req_addr = 32'h10; req_wdata = 32'hAAAA5555;
    req_valid2 = 1'b1;
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready2), 32'd1);
    chk("midrst_valid", 32'(rsp_valid2), 32'd0);
    txn(0, 1'b0, F3_W, 32'h10, 32'd0, 0, rd, er);
    chk("midrst_word", rd, 32'd0);

    txn(0, 1'b1, F3_W,  32'h20, 32'hDEADBEEF, 0, rd, er);
    txn(0, 1'b0, F3_W,  32'h20, 32'd0, 0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);
    txn(0, 1'b1, F3_W,  32'h20, 32'd0, 0, rd, er);
    txn(0, 1'b1, F3_B,  32'h21, 32'h00000080, 0, rd, er);
    txn(0, 1'b0, F3_B,  32'h21, 32'd0, 0, rd, er);
    chk("lb21", rd, 32'hFFFFFF80);
    txn(0, 1'b0, F3_BU, 32'h21, 32'd0, 0, rd, er);
    chk("lbu21", rd, 32'h00000080);
    txn(0, 1'b0, F3_W,  32'h20, 32'd0, 0, rd, er);
    chk("lw20", rd, 32'h00008000);
    txn(0, 1'b1, F3_H,  32'h22, 32'h00001234, 0, rd, er);
    txn(0, 1'b0, F3_HU, 32'h22, 32'd0, 0, rd, er);
    chk("lhu22", rd, 32'h00001234);
    txn(0, 1'b0, F3_H,  32'h23, 32'd0, 0, rd, er);
    chk("lh23_err", 32'(er), 32'd1);
    txn(0, 1'b1, F3_W,  32'h26, 32'hFFFFFFFF, 0, rd, er);
    chk("sw26_err", 32'(er), 32'd1);
    txn(0, 1'b0, F3_W,  32'h24, 32'd0, 0, rd, er);
    chk("lw24_unchanged", rd, 32'd0);
    txn(0, 1'b0, F3_W,  32'h20, 32'd0, 5, rd, er);
    chk("bp_word", rd, 32'h12348000);

    for (int i = 0; i < 30; i++)
      txn(0, 1'($urandom), 3'($urandom_range(0, 7)), rand_addr(), $urandom,
          $urandom_range(0, 2), rd, er);

    txn(1, 1'b0, F3_W, 32'h4000, 32'd0, 0, rd, er);
    chk("w0_range_err", 32'(er), 32'd1);
    txn(1, 1'b1, F3_W, 32'h20, 32'hCAFEF00D, 0, rd, er);

    // Back-to-back loads with the consumer always ready: one response per two cycles.
    @(negedge clk);
    req_we = 1'b0; req_f3 = F3_W; req_addr = 32'h20; req_wdata = 32'd0;
    req_valid0 = 1'b1;
    rsp_ready0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(rsp_valid0), 32'(i % 2));
      if (i % 2 == 1) chk("b2b_rdata", rsp_rdata0, 32'hCAFEF00D);
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b0;
    $display("[TB] dut1 back-to-back lw @00000020 x6 done");

    for (int i = 0; i < 20; i++)
      txn(1, 1'($urandom), 3'($urandom_range(0, 7)), rand_addr(), $urandom,
          $urandom_range(0, 1), rd, er);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
